// File: rtl/axi_lite_regfile.sv
// Control/status register file behind the AXI-Lite slave's local bus.
// ID, CTRL, W1C STATUS, free-running CNT with compare, and scratch registers.
module axi_lite_regfile #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          NUM_SCRATCH = 4,
    parameter logic [31:0] ID_VALUE    = 32'hA11E0001
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [ADDR_WIDTH-1:0]   user_wr_addr,
    input  logic [DATA_WIDTH-1:0]   user_wr_data,
    input  logic [DATA_WIDTH/8-1:0] user_wr_strb,
    input  logic                    user_wr_en,
    output logic [1:0]              user_wr_resp,
    input  logic [ADDR_WIDTH-1:0]   user_rd_addr,
    input  logic                    user_rd_en,
    output logic [DATA_WIDTH-1:0]   user_rd_data,
    output logic [1:0]              user_rd_resp,
    output logic                    ctrl_cnt_en,
    output logic                    irq
);

    typedef enum logic [2:0] {
        R_ID,
        R_CTRL,
        R_STAT,
        R_CNT,
        R_CMP,
        R_SCR,
        R_NONE
    } reg_sel_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic reg_sel_e decode(input logic [7:0] off);
        logic [5:0] word;
        word   = off[7:2];
        decode = R_NONE;
        if (off[1:0] == 2'b00) begin
            case (word)
                6'd0: decode = R_ID;
                6'd1: decode = R_CTRL;
                6'd2: decode = R_STAT;
                6'd3: decode = R_CNT;
                6'd4: decode = R_CMP;
                default: begin
                    if (word >= 6'd8 && int'(word) < 8 + NUM_SCRATCH) begin
                        decode = R_SCR;
                    end
                end
            endcase
        end
    endfunction

    logic [4:0]            ctrl_q;
    logic [1:0]            status_q;
    logic [31:0]           cnt_q;
    logic [31:0]           cmp_q;
    logic [DATA_WIDTH-1:0] scratch_q [NUM_SCRATCH];

    reg_sel_e              wr_sel;
    reg_sel_e              rd_sel;
    logic [5:0]            wr_idx;
    logic [5:0]            rd_idx;
    logic                  wr_err;
    logic                  wr_ok;
    logic [DATA_WIDTH-1:0] wr_mask;
    logic [DATA_WIDTH-1:0] ctrl_rd;
    logic [DATA_WIDTH-1:0] ctrl_merge;
    logic [DATA_WIDTH-1:0] cmp_merge;
    logic                  cnt_clr;
    logic                  cmp_hit;
    logic                  wrap;
    logic [1:0]            w1c;
    logic [1:0]            status_d;
    logic [31:0]           cnt_d;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  irq_d;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{user_wr_addr[ADDR_WIDTH-1:8],
                                user_rd_addr[ADDR_WIDTH-1:8]};

    assign wr_sel = decode(user_wr_addr[7:0]);
    assign rd_sel = decode(user_rd_addr[7:0]);
    assign wr_idx = user_wr_addr[7:2] - 6'd8;
    assign rd_idx = user_rd_addr[7:2] - 6'd8;

    assign wr_err = (wr_sel == R_NONE) || (wr_sel == R_ID) ||
                    (wr_sel == R_CNT);
    assign wr_ok  = user_wr_en && !wr_err;

    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            wr_mask[8*i +: 8] = {8{user_wr_strb[i]}};
        end
    end

    // cnt_clr is never stored, so bit 1 always reads back as zero
    assign ctrl_rd    = DATA_WIDTH'(ctrl_q);
    assign ctrl_merge = (ctrl_rd & ~wr_mask) | (user_wr_data & wr_mask);
    assign cmp_merge  = (cmp_q & ~wr_mask) | (user_wr_data & wr_mask);

    assign cnt_clr = wr_ok && (wr_sel == R_CTRL) &&
                     user_wr_strb[0] && user_wr_data[1];

    // Hardware events use the pre-write CTRL and CMP values
    assign cmp_hit = ctrl_q[0] && (cnt_q == cmp_q);
    assign wrap    = ctrl_q[0] && !cnt_clr && (cnt_q == 32'hFFFF_FFFF);

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (ctrl_q[0]) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    assign w1c = (wr_ok && wr_sel == R_STAT && user_wr_strb[0]) ?
                 user_wr_data[1:0] : 2'b00;
    // Set after clear so a same-cycle hardware event wins
    assign status_d = (status_q & ~w1c) | {cmp_hit, wrap};

    assign irq_d = ctrl_q[2] && ((status_q[0] && ctrl_q[3]) ||
                                 (status_q[1] && ctrl_q[4]));

    always_comb begin
        rd_val = '0;
        case (rd_sel)
            R_ID:    rd_val = DATA_WIDTH'(ID_VALUE);
            R_CTRL:  rd_val = ctrl_rd;
            R_STAT:  rd_val = DATA_WIDTH'(status_q);
            R_CNT:   rd_val = DATA_WIDTH'(cnt_q);
            R_CMP:   rd_val = DATA_WIDTH'(cmp_q);
            R_SCR: begin
                for (int k = 0; k < NUM_SCRATCH; k++) begin
                    if (int'(rd_idx) == k) begin
                        rd_val = scratch_q[k];
                    end
                end
            end
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            ctrl_q       <= '0;
            status_q     <= '0;
            cnt_q        <= '0;
            cmp_q        <= 32'hFFFF_FFFF;
            user_wr_resp <= RESP_OKAY;
            user_rd_resp <= RESP_OKAY;
            user_rd_data <= '0;
            irq          <= 1'b0;
            for (int k = 0; k < NUM_SCRATCH; k++) begin
                scratch_q[k] <= '0;
            end
        end else begin
            if (user_wr_en) begin
                user_wr_resp <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end
            if (user_rd_en) begin
                if (rd_sel == R_NONE) begin
                    user_rd_data <= '0;
                    user_rd_resp <= RESP_SLVERR;
                end else begin
                    user_rd_data <= rd_val;
                    user_rd_resp <= RESP_OKAY;
                end
            end
            if (wr_ok && wr_sel == R_CTRL) begin
                ctrl_q <= ctrl_merge[4:0] & 5'b11101;
            end
            if (wr_ok && wr_sel == R_CMP) begin
                cmp_q <= cmp_merge[31:0];
            end
            for (int k = 0; k < NUM_SCRATCH; k++) begin
                if (wr_ok && wr_sel == R_SCR && int'(wr_idx) == k) begin
                    scratch_q[k] <= (scratch_q[k] & ~wr_mask) |
                                    (user_wr_data & wr_mask);
                end
            end
            cnt_q    <= cnt_d;
            status_q <= status_d;
            irq      <= irq_d;
        end
    end

    assign ctrl_cnt_en = ctrl_q[0];

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Bench for axi_lite_regfile: directed scenarios plus random bus traffic
// checked against a register-level reference model.
module tb_axi_lite_regfile;

    localparam int NS = 4;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] wa, wd, ra;
    logic [3:0]  ws;
    logic        we, re;
    logic [1:0]  wr_resp, rd_resp;
    logic [31:0] rd_data;
    logic        cnt_en_o, irq_o;

    always #5 aclk = ~aclk;

    axi_lite_regfile #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_SCRATCH(NS),
        .ID_VALUE   (32'hA11E0001)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .user_wr_addr(wa),
        .user_wr_data(wd),
        .user_wr_strb(ws),
        .user_wr_en  (we),
        .user_wr_resp(wr_resp),
        .user_rd_addr(ra),
        .user_rd_en  (re),
        .user_rd_data(rd_data),
        .user_rd_resp(rd_resp),
        .ctrl_cnt_en (cnt_en_o),
        .irq         (irq_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state, kept as named register fields
    bit        m_en, m_ie, m_wm, m_cm;
    bit [1:0]  m_st;
    bit [31:0] m_cnt, m_cmp;
    bit [31:0] m_scr [NS];
    bit        m_irq;
    bit [31:0] e_rdata;
    bit [1:0]  e_rresp, e_wresp;

    // -1 unmapped, 0 ID, 1 CTRL, 2 STATUS, 3 CNT, 4 CMP, 8+k SCRATCH[k]
    function automatic int reg_of(input logic [31:0] a);
        int off;
        off = int'(a[7:0]);
        if (off % 4 != 0) return -1;
        if (off <= 16) return off / 4;
        if (off >= 32 && (off - 32) / 4 < NS) return 8 + (off - 32) / 4;
        return -1;
    endfunction

    function automatic bit [31:0] m_val(input int r);
        case (r)
            0: return 32'hA11E0001;
            1: return {27'b0, m_cm, m_wm, m_ie, 1'b0, m_en};
            2: return {30'b0, m_st};
            3: return m_cnt;
            4: return m_cmp;
            default: return m_scr[r-8];
        endcase
    endfunction

    task automatic model_edge(input bit w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s,
                              input bit r, input logic [31:0] b,
                              input bit rst);
        bit [31:0] bm, nv;
        bit        ok, clr, irq_n;
        bit [1:0]  w1c, hw;
        int        rw, rr;
        if (rst) begin
            {m_en, m_ie, m_wm, m_cm} = '0;
            m_st = 0; m_cnt = 0; m_cmp = 32'hFFFFFFFF;
            for (int k = 0; k < NS; k++) m_scr[k] = 0;
            m_irq = 0; e_rdata = 0; e_rresp = 0; e_wresp = 0;
            return;
        end
        if (r) begin
            rr = reg_of(b);
            if (rr < 0) begin
                e_rdata = 0; e_rresp = 2'b10;
            end else begin
                e_rdata = m_val(rr); e_rresp = 2'b00;
            end
        end
        for (int i = 0; i < 4; i++) bm[8*i +: 8] = {8{s[i]}};
        rw  = w ? reg_of(a) : -1;
        ok  = w && rw >= 0 && rw != 0 && rw != 3;
        if (w) e_wresp = ok ? 2'b00 : 2'b10;
        clr = ok && rw == 1 && s[0] && d[1];
        w1c = (ok && rw == 2 && s[0]) ? d[1:0] : 2'b00;
        hw  = 0;
        irq_n = m_ie && ((m_st[0] && m_wm) || (m_st[1] && m_cm));
        if (m_en && m_cnt == m_cmp) hw[1] = 1;
        if (clr) m_cnt = 0;
        else if (m_en) begin
            if (m_cnt == 32'hFFFFFFFF) hw[0] = 1;
            m_cnt = m_cnt + 1;
        end
        m_st  = (m_st & ~w1c) | hw;
        m_irq = irq_n;
        if (ok) begin
            if (rw == 1) begin
                nv = (m_val(1) & ~bm) | (d & bm);
                m_en = nv[0]; m_ie = nv[2]; m_wm = nv[3]; m_cm = nv[4];
            end else if (rw == 4) begin
                m_cmp = (m_cmp & ~bm) | (d & bm);
            end else if (rw >= 8) begin
                m_scr[rw-8] = (m_scr[rw-8] & ~bm) | (d & bm);
            end
        end
    endtask

    task automatic bus(input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input bit r, input logic [31:0] b, input bit rst);
        we = w; wa = a; wd = d; ws = s; re = r; ra = b; areset = rst;
        @(posedge aclk);
        model_edge(w, a, d, s, r, b, rst);
        #1;
        check("rd_data", rd_data, e_rdata);
        check("rd_resp", 32'(rd_resp), 32'(e_rresp));
        check("wr_resp", 32'(wr_resp), 32'(e_wresp));
        check("irq", 32'(irq_o), 32'(m_irq));
        check("cnt_en", 32'(cnt_en_o), 32'(m_en));
        we = 0; re = 0; areset = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        bus(1, a, d, s, 0, 0, 0);
    endtask

    task automatic rd(input logic [31:0] a);
        bus(0, 0, 0, 0, 1, a, 0);
    endtask

    task automatic idle();
        bus(0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [7:0] offs [14];
        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20,
                 8'h24, 8'h28, 8'h2C, 8'h30, 8'h40, 8'h06, 8'h00};
        offs[13] = 8'($urandom);
        return {24'($urandom), offs[$urandom_range(0, 13)]};
    endfunction

    initial begin
        we = 0; re = 0; wa = 0; wd = 0; ws = 0; ra = 0; areset = 1;
        bus(0, 0, 0, 0, 0, 0, 1);
        bus(0, 0, 0, 0, 0, 0, 1);

        rd(32'h00);
        check("id_value", rd_data, 32'hA11E0001);
        check("id_resp", 32'(rd_resp), 32'h0);
        rd(32'h10);
        check("cmp_reset", rd_data, 32'hFFFFFFFF);
        rd(32'h20);
        check("scr_reset", rd_data, 32'h0);

        wr(32'h20, 32'hDEADBEEF, 4'b0101);
        check("scr_wresp", 32'(wr_resp), 32'h0);
        rd(32'h20);
        check("scr_strb", rd_data, 32'h00AD00EF);

        wr(32'h00, 32'h1234, 4'hF);
        check("id_wr_err", 32'(wr_resp), 32'h2);
        wr(32'h0C, 32'h1234, 4'hF);
        check("cnt_wr_err", 32'(wr_resp), 32'h2);
        rd(32'h40);
        check("unmap_rresp", 32'(rd_resp), 32'h2);
        check("unmap_rdata", rd_data, 32'h0);
        rd(32'h06);
        check("misalign_rresp", 32'(rd_resp), 32'h2);
        rd(32'h0C);
        check("cnt_unchanged", rd_data, 32'h0);

        wr(32'h10, 32'd5, 4'hF);
        wr(32'h04, 32'h15, 4'hF);
        repeat (8) idle();
        rd(32'h08);
        check("cmp_status", rd_data, 32'h2);
        check("cmp_irq", 32'(irq_o), 32'h1);
        wr(32'h08, 32'h2, 4'h1);
        check("irq_lag", 32'(irq_o), 32'h1);
        idle();
        check("irq_drop", 32'(irq_o), 32'h0);

        wr(32'h08, 32'h3, 4'hF);
        wr(32'h04, 32'h0D, 4'hF);
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1 release dut.cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        idle();
        wr(32'h08, 32'h1, 4'h1);
        rd(32'h08);
        check("wrap_set_wins", 32'(rd_data[0]), 32'h1);
        check("wrap_irq", 32'(irq_o), 32'h1);
        wr(32'h08, 32'h1, 4'h1);
        rd(32'h08);
        check("wrap_w1c", 32'(rd_data[0]), 32'h0);

        wr(32'h24, 32'h12345678, 4'hF);
        bus(1, 32'h24, 32'hFFFFFFFF, 4'hF, 1, 32'h24, 1);
        check("rst_rdata", rd_data, 32'h0);
        check("rst_irq", 32'(irq_o), 32'h0);
        check("rst_cnt_en", 32'(cnt_en_o), 32'h0);
        rd(32'h24);
        check("rst_scr1", rd_data, 32'h0);

        repeat (3000) begin
            bus(1'($urandom), rand_addr(), $urandom, 4'($urandom),
                1'($urandom), rand_addr(), $urandom_range(0, 299) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
